// File: rtl/expr_emitter_if.sv
// ----------------------------------------------------------------------------
// expr_emitter_if
//   Character stream link between the expression emitter and its sink.
//   ch        : ASCII character presented by the emitter
//   ch_valid  : ch is valid
//   ch_ready  : sink accepts ch; a transfer happens when both are high at an edge
//   master    : emitter side (drives ch/ch_valid, samples ch_ready)
//   slave     : sink side
// ----------------------------------------------------------------------------
interface expr_emitter_if;
    logic [7:0] ch;
    logic       ch_valid;
    logic       ch_ready;

    modport master (output ch, output ch_valid, input  ch_ready);
    modport slave  (input  ch, input  ch_valid, output ch_ready);
endinterface

// File: rtl/expr_emitter.sv
// ----------------------------------------------------------------------------
// expr_emitter
//   Serialises a compact expression descriptor (digits, '+'/'*' operators and
//   one optional parenthesised group) into an ASCII stream, one byte per
//   accepted handshake.
//
//   Ports
//     clk, clr_n        : clock, asynchronous active-low reset
//     start             : load request, sampled only while idle
//     term_cnt          : number of terms (1..MAX_TERMS)
//     digits            : term i value in digits[4i+3:4i] (0..9)
//     ops               : bit i = operator after term i (0 '+', 1 '*')
//     grp_start/grp_len : first term / length of the parenthesised group
//     busy              : a descriptor is being emitted
//     done              : one-cycle pulse after the final transfer
//     err               : one-cycle pulse after a rejected start
//     tx                : character stream (expr_emitter_if.master)
//
//   Build option
//     EXPR_EMITTER_TERM_EN : append a line-feed (0x0A) terminator to each
//                            stream; done then follows the terminator.
// ----------------------------------------------------------------------------
module expr_emitter #(
    parameter int MAX_TERMS = 8
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [3:0]             term_cnt,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-1:0]   ops,
    input  logic [3:0]             grp_start,
    input  logic [3:0]             grp_len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    expr_emitter_if.master         tx
);

    // EMIT is split into per-character sub-states; the state register names
    // the character currently held in ch_q, idx_q names its term.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OPEN  = 3'd1;
    localparam logic [2:0] S_DIGIT = 3'd2;
    localparam logic [2:0] S_CLOSE = 3'd3;
    localparam logic [2:0] S_OP    = 3'd4;
`ifdef EXPR_EMITTER_TERM_EN
    localparam logic [2:0] S_TERM  = 3'd5;
    localparam logic [2:0] S_END   = S_TERM;
`else
    localparam logic [2:0] S_END   = S_IDLE;
`endif

    localparam logic [3:0] MAXT = 4'(MAX_TERMS);

    logic [2:0]             st_q,   st_d;
    logic [3:0]             idx_q,  idx_d;
    logic [7:0]             ch_q,   ch_d;
    logic                   vld_q,  vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q,  err_d;

    // Latched descriptor, held for the whole stream
    logic [3:0]             tc_q, gs_q, gl_q;
    logic [4*MAX_TERMS-1:0] dig_q;
    logic [MAX_TERMS-1:0]   ops_q;

    logic                   dig_ok, desc_ok, load, open0;
    logic [4:0]             grp_end;
    logic [2:0]             nxt_st;
    logic [3:0]             nxt_idx;
    logic                   last, close_here, open_next;
    logic [3:0]             nxt_dig;
    logic                   nxt_op;

    function automatic logic [7:0] char_of(input logic [2:0] st, input logic [3:0] d,
                                           input logic op);
        case (st)
            S_OPEN:  char_of = 8'h28;
            S_DIGIT: char_of = 8'h30 + {4'h0, d};
            S_CLOSE: char_of = 8'h29;
            S_OP:    char_of = op ? 8'h2A : 8'h2B;
`ifdef EXPR_EMITTER_TERM_EN
            S_TERM:  char_of = 8'h0A;
`endif
            default: char_of = 8'h00;
        endcase
    endfunction

    // ---------------- descriptor check (raw inputs, idle only) --------------
    always_comb begin
        dig_ok = 1'b1;
        for (int k = 0; k < MAX_TERMS; k++)
            if (k[3:0] < term_cnt && digits[4*k +: 4] > 4'd9) dig_ok = 1'b0;
    end

    // 5-bit sum so a large start+len cannot wrap back into range
    assign grp_end = {1'b0, grp_start} + {1'b0, grp_len};
    assign desc_ok = (term_cnt != 4'd0) && (term_cnt <= MAXT) && dig_ok &&
                     ((grp_len == 4'd0) || (grp_end <= {1'b0, term_cnt}));
    assign load    = (st_q == S_IDLE) && start && desc_ok;
    assign open0   = (grp_len != 4'd0) && (grp_start == 4'd0);

    // ---------------- successor of the character being presented ------------
    // Phases whose condition is false are skipped here, so the next character
    // is ready in ch_d on the transfer edge with no bubble.
    assign last       = ({1'b0, idx_q} + 5'd1) == {1'b0, tc_q};
    assign close_here = (gl_q != 4'd0) &&
                        ({1'b0, idx_q} == ({1'b0, gs_q} + {1'b0, gl_q} - 5'd1));
    assign open_next  = (gl_q != 4'd0) && ((idx_q + 4'd1) == gs_q);

    always_comb begin
        nxt_st  = S_IDLE;
        nxt_idx = idx_q;
        case (st_q)
            S_OPEN:  nxt_st = S_DIGIT;
            S_DIGIT: nxt_st = close_here ? S_CLOSE : (last ? S_END : S_OP);
            S_CLOSE: nxt_st = last ? S_END : S_OP;
            S_OP: begin
                nxt_idx = idx_q + 4'd1;
                nxt_st  = open_next ? S_OPEN : S_DIGIT;
            end
            default: nxt_st = S_IDLE;
        endcase
    end

    always_comb begin
        nxt_dig = 4'd0;
        nxt_op  = 1'b0;
        for (int k = 0; k < MAX_TERMS; k++) begin
            if (k[3:0] == nxt_idx) begin
                nxt_dig = dig_q[4*k +: 4];
                nxt_op  = ops_q[k];
            end
        end
    end

    // ---------------- next-state ----------------
    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (st_q == S_IDLE) begin
            if (start && !desc_ok) begin
                err_d = 1'b1;
            end else if (load) begin
                idx_d  = 4'd0;
                st_d   = open0 ? S_OPEN : S_DIGIT;
                ch_d   = open0 ? 8'h28 : (8'h30 + {4'h0, digits[3:0]});
                vld_d  = 1'b1;
                busy_d = 1'b1;
            end
        end else if (vld_q && tx.ch_ready) begin
            st_d  = nxt_st;
            idx_d = nxt_idx;
            if (nxt_st == S_IDLE) begin
                vld_d  = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
                ch_d   = 8'h00;
            end else begin
                ch_d = char_of(nxt_st, nxt_dig, nxt_op);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st_q   <= S_IDLE;
            idx_q  <= 4'd0;
            ch_q   <= 8'h00;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            tc_q   <= 4'd0;
            gs_q   <= 4'd0;
            gl_q   <= 4'd0;
            dig_q  <= '0;
            ops_q  <= '0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            ch_q   <= ch_d;
            vld_q  <= vld_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
            if (load) begin
                tc_q  <= term_cnt;
                gs_q  <= grp_start;
                gl_q  <= grp_len;
                dig_q <= digits;
                ops_q <= ops;
            end
        end
    end

    assign tx.ch       = ch_q;
    assign tx.ch_valid = vld_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_expr_emitter.sv
// ----------------------------------------------------------------------------
// tb_expr_emitter
//   Directed cases from the test plan plus randomized descriptors, checked
//   against a string-building reference model of the expression format.
// ----------------------------------------------------------------------------
module tb_expr_emitter;
    localparam int MAXT = 8;
`ifdef EXPR_EMITTER_TERM_EN
    localparam int TERM_N = 1;
`else
    localparam int TERM_N = 0;
`endif

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        term_cnt = '0, grp_start = '0, grp_len = '0;
    logic [4*MAXT-1:0] digits = '0;
    logic [MAXT-1:0]   ops = '0;
    logic              busy, done, err;

    expr_emitter_if tx_if ();

    expr_emitter #(.MAX_TERMS(MAXT)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .term_cnt  (term_cnt),
        .digits    (digits),
        .ops       (ops),
        .grp_start (grp_start),
        .grp_len   (grp_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tx        (tx_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    byte unsigned exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // inputs change #1 after the rising edge; outputs are sampled there too
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal_desc();
        if (term_cnt == 4'd0 || int'(term_cnt) > MAXT) return 1'b0;
        for (int i = 0; i < int'(term_cnt); i++)
            if (digits[4*i +: 4] > 4'd9) return 1'b0;
        if (grp_len != 4'd0 && int'(grp_start) + int'(grp_len) > int'(term_cnt)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void build_exp();
        exp_q.delete();
        for (int i = 0; i < int'(term_cnt); i++) begin
            if (grp_len != 0 && i == int'(grp_start)) exp_q.push_back(8'h28);
            exp_q.push_back(8'h30 + {4'h0, digits[4*i +: 4]});
            if (grp_len != 0 && i == int'(grp_start) + int'(grp_len) - 1) exp_q.push_back(8'h29);
            if (i < int'(term_cnt) - 1) exp_q.push_back(ops[i] ? 8'h2A : 8'h2B);
        end
        if (TERM_N != 0) exp_q.push_back(8'h0A);
    endfunction

    task automatic set_desc(input int tc, input logic [4*MAXT-1:0] d, input logic [MAXT-1:0] o,
                            input int gs, input int gl);
        term_cnt  = 4'(tc);
        digits    = d;
        ops       = o;
        grp_start = 4'(gs);
        grp_len   = 4'(gl);
    endtask

    task automatic rand_legal();
        int tc, gs;
        tc = $urandom_range(1, MAXT);
        for (int i = 0; i < MAXT; i++)
            digits[4*i +: 4] = 4'((i < tc) ? $urandom_range(0, 9) : $urandom_range(0, 15));
        ops      = MAXT'($urandom);
        term_cnt = 4'(tc);
        if ($urandom_range(0, 2) == 0) begin
            grp_len   = 4'd0;
            grp_start = 4'($urandom_range(0, 15));
        end else begin
            gs        = $urandom_range(0, tc - 1);
            grp_start = 4'(gs);
            grp_len   = 4'($urandom_range(1, tc - gs));
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: 3-cycle stalls on chars 2 and 5
    // poke: pulse start with scrambled descriptor inputs mid-stream
    task automatic run_stream(input string tag, input int mode, input bit poke);
        int k, nc, stl;
        bit bad_vld, bad_hold, spur, was_stall;
        logic [7:0] held;
        k = 0; nc = 0; stl = 0;
        bad_vld = 0; bad_hold = 0; spur = 0; was_stall = 0; held = 8'h00;
        build_exp();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk({tag, "_first_vld"}, 32'(tx_if.ch_valid), 32'd1);
        while (k < exp_q.size() && nc < 400) begin
            case (mode)
                0:       tx_if.ch_ready = 1'b1;
                1:       tx_if.ch_ready = ($urandom_range(0, 2) != 0);
                default: tx_if.ch_ready = !((k == 1 || k == 4) && stl < 3);
            endcase
            if (poke && nc == 2) begin
                start    = 1'b1;
                term_cnt = 4'($urandom);
                digits   = (4*MAXT)'($urandom);
                ops      = MAXT'($urandom);
            end
            if (!tx_if.ch_valid || !busy) bad_vld = 1'b1;
            if (was_stall && tx_if.ch !== held) bad_hold = 1'b1;
            if (err || done) spur = 1'b1;
            if (tx_if.ch_ready) begin
                chk($sformatf("%s_ch%0d", tag, k), 32'(tx_if.ch), 32'(exp_q[k]));
                k++;
                stl = 0;
                was_stall = 1'b0;
            end else begin
                stl++;
                was_stall = 1'b1;
                held = tx_if.ch;
            end
            cyc();
            start = 1'b0;
            nc++;
        end
        chk({tag, "_count"}, 32'(k), 32'(exp_q.size()));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_vld_off"}, 32'(tx_if.ch_valid), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_vld_held"}, 32'(bad_vld), 32'd0);
        chk({tag, "_ch_stable"}, 32'(bad_hold), 32'd0);
        chk({tag, "_no_pulse"}, 32'(spur), 32'd0);
        if (mode == 0) chk({tag, "_cycles"}, 32'(nc), 32'(exp_q.size()));
        if (mode == 2) chk({tag, "_cycles"}, 32'(nc), 32'(exp_q.size() + 6));
    endtask

    task automatic run_reject(input string tag);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_no_vld"}, 32'(tx_if.ch_valid), 32'd0);
        chk({tag, "_no_busy"}, 32'(busy), 32'd0);
        cyc();
        chk({tag, "_err_clr"}, 32'(err), 32'd0);
        chk({tag, "_no_vld2"}, 32'(tx_if.ch_valid), 32'd0);
    endtask

    initial begin
        tx_if.ch_ready = 1'b0;
        #12;
        chk("rst_ch",   32'(tx_if.ch), 32'h00);
        chk("rst_vld",  32'(tx_if.ch_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err",  32'(err), 32'd0);
        clr_n = 1'b1;
        cyc();

        // basic stream "1+(2*3)", done then low one cycle later
        set_desc(3, 32'h0000_0321, 8'b0000_0010, 1, 2);
        run_stream("basic", 0, 1'b0);
        cyc();
        chk("basic_done_clr", 32'(done), 32'd0);

        // "(9)"
        set_desc(1, 32'h0000_0009, 8'h00, 0, 1);
        run_stream("single", 0, 1'b0);

        // back-to-back: start accepted in the done cycle, with backpressure
        set_desc(3, 32'h0000_0321, 8'b0000_0010, 1, 2);
        run_stream("bp", 2, 1'b0);
        cyc();

        // rejections; the unused digit slot holds 0xF to show it is ignored
        set_desc(0, 32'h0000_0321, 8'h00, 0, 0);
        run_reject("rej_tc0");
        set_desc(3, 32'hF000_0A21, 8'h00, 0, 0);
        run_reject("rej_dig");
        set_desc(3, 32'h0000_0321, 8'h00, 2, 2);
        run_reject("rej_grp");
        set_desc(9, 32'h0000_0000, 8'h00, 0, 0);
        run_reject("rej_tcmax");
        set_desc(3, 32'hFFFF_F321, 8'h00, 2, 1);
        run_stream("grp_edge", 0, 1'b0);

        // reset after three transfers
        set_desc(3, 32'h0000_0321, 8'b0000_0010, 1, 2);
        tx_if.ch_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        #2 clr_n = 1'b0;
        #1;
        chk("mrst_vld",  32'(tx_if.ch_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        cyc();
        clr_n = 1'b1;
        cyc();
        chk("mrst_idle_done", 32'(done), 32'd0);
        set_desc(3, 32'h0000_0321, 8'b0000_0010, 1, 2);
        run_stream("after_rst", 0, 1'b0);

        // start while busy, with inputs scrambled mid-stream
        set_desc(4, 32'h0000_5678, 8'b0000_0101, 0, 4);
        run_stream("poke", 0, 1'b1);
        cyc();

        // randomized descriptors
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                rand_legal();
            end else begin
                term_cnt  = 4'($urandom);
                digits    = (4*MAXT)'($urandom);
                ops       = MAXT'($urandom);
                grp_start = 4'($urandom_range(0, 15));
                grp_len   = 4'($urandom_range(0, 15));
            end
            if (legal_desc())
                run_stream($sformatf("rnd%0d", n), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            else
                run_reject($sformatf("rrej%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/expr_emitter.md
# expr_emitter

- Serialises a compact expression descriptor into an ASCII character stream, one byte per accepted handshake.
- Every stream it emits is accepted by the team's expression-string checker, which recognises digit/operator sequences with one level of parentheses.
- It drives checker and parser test traffic, and it is the transmit side of the expression link.
- A descriptor is latched on `start`. The emitter then walks the terms and presents characters under valid/ready flow control.

## Interface
- `MAX_TERMS`, default 8: maximum number of operand terms. Legal range is 1..15.
- `clk`  in  1: rising-edge clock.
- `clr_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to load the descriptor. Sampled only in IDLE.
- `term_cnt`  in  4: number of terms. Legal range is 1..MAX_TERMS.
- `digits`  in  4*MAX_TERMS: term i value is `digits[4i+3:4i]`. Legal range is 0..9.
- `ops`  in  MAX_TERMS: bit i selects the operator after term i. 0 = '+' (0x2B), 1 = '*' (0x2A). Bit term_cnt-1 and above are ignored.
- `grp_start`  in  4: index of the first term inside parentheses.
- `grp_len`  in  4: number of terms inside parentheses. 0 = no group.
- `ch`  out  8: character presented to the sink.
- `ch_valid`  out  1: `ch` is valid.
- `ch_ready`  in  1: the sink accepts `ch`. A transfer happens when `ch_valid` and `ch_ready` are both high at a rising edge.
- `busy`  out  1: a descriptor is being emitted.
- `done`  out  1: one-cycle pulse after the final transfer.
- `err`  out  1: one-cycle pulse when a `start` is rejected.

## Operation
- Reset (`clr_n` low) takes effect immediately and asynchronously:
  - state = IDLE;
  - `ch` = 0x00, `ch_valid` = 0, `busy` = 0, `done` = 0, `err` = 0.
- Descriptor check at `start` in IDLE. All of the following must hold:
  - `1 <= term_cnt <= MAX_TERMS`;
  - every used digit is <= 9;
  - `grp_len == 0`, or `grp_start + grp_len <= term_cnt` (computed in 5 bits, no wrap).
- On a failed check: pulse `err` and stay in IDLE.
- On a passed check: latch all descriptor inputs, set `busy`, and enter EMIT.
- Character order for each term i, from 0 to term_cnt-1:
  1. '(' (0x28) if `grp_len != 0` and `i == grp_start`;
  2. the digit, as 0x30 + `digits[i]`;
  3. ')' (0x29) if `grp_len != 0` and `i == grp_start + grp_len - 1`;
  4. the operator from `ops[i]` if `i < term_cnt - 1`.
- States:
  - IDLE;
  - OPEN, DIGIT, CLOSE, OP (sub-states of EMIT, tracked with a term index and a phase);
  - TERM (only when the terminator is configured in, see Configuration).
- A phase whose condition is false is skipped with no bubble cycle.
- After the last character transfers, the block returns to IDLE.
- A `start` while `busy` is high is ignored. Neither `err` nor `done` pulses.
- Latched descriptor bits are held for the whole stream. Input changes during EMIT have no effect.

## Timing
- `ch_valid` rises on the cycle after `start` is accepted.
- `ch` and `ch_valid` are registered. While `ch_valid` is high and `ch_ready` is low, `ch` holds stable. `ch_valid` never drops without a transfer, except on reset.
- After a transfer, the next character is presented in the following cycle, so `ch_valid` stays high. With `ch_ready` held high, one character transfers per cycle.
- At the edge of the final transfer:
  - `ch_valid` falls;
  - `busy` falls;
  - `done` is high for exactly that next cycle.
- The earliest next `start` is accepted in the cycle in which `done` is high.
- `err` is high for the cycle after the rejected `start`.
- Reset mid-stream: the stream is abandoned with no terminator and no `done`. `ch_valid` drops asynchronously.

## Configuration
- Macro: `EXPR_EMITTER_TERM_EN`.
- Defined: after the last expression character, TERM emits a line-feed terminator 0x0A under the same handshake. `done` follows the terminator's transfer.
- Undefined: the TERM state is not built. `done` follows the last expression character.

## Test plan
- Basic stream:
  - descriptor: term_cnt=3, digits 1,2,3; ops[0]='+', ops[1]='*'; grp_start=1, grp_len=2; `ch_ready`=1.
  - required: 0x31 0x2B 0x28 0x32 0x2A 0x33 0x29 on 7 consecutive cycles; `done` one cycle after the 7th transfer.
- Single grouped term:
  - descriptor: term_cnt=1, digit 9, grp_start=0, grp_len=1.
  - required: "(9)" = 0x28 0x39 0x29, then `done`; with the macro defined, 0x0A before `done`.
- Backpressure:
  - same descriptor as the basic stream; `ch_ready` low for 3 cycles on the 2nd and the 5th character.
  - required: `ch` held stable and `ch_valid` high while stalled; order unchanged; 13 cycles from first valid to `done`.
- Rejection:
  - start with term_cnt=0 -> `err` pulse, no `ch_valid`;
  - start with digit 0xA -> `err` pulse, no `ch_valid`;
  - start with grp_start=2, grp_len=2 at term_cnt=3 -> `err` pulse, no `ch_valid`.
- Reset mid-stream and start while busy:
  - `clr_n` low after 3 transfers -> `ch_valid`, `busy` and `done` all 0 immediately;
  - a new start is then accepted normally;
  - a `start` pulsed during an active stream has no effect on the output sequence.
